// File: rtl/edge_count_scheduler_pkg.sv
// Shared definitions for the time-shared edge-count measurement block:
// FSM state encoding and the channel-index width helper.
package edge_count_scheduler_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SELECT = 2'd1;
    localparam state_t ST_GATE   = 2'd2;
    localparam state_t ST_REPORT = 2'd3;

    // A single channel still needs a 1-bit index port.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edge_count_scheduler_sync.sv
// Saturating rising-edge counter fed by an already-synchronized input.
// clr resets the count and primes prev from din so a mux switch is not seen as an edge.
module sync_edge_counter
    import edge_count_scheduler_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          din,
    output logic [CW-1:0] count,
    output logic          ovf
);

    logic prev;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
            prev  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
            prev  <= din;
        end else if (en) begin
            prev <= din;
            if (din && !prev) begin
                if (count == '1) ovf <= 1'b1;
                count <= sat_inc(count);
            end
        end
    end

endmodule

// File: rtl/edge_count_scheduler.sv
// Sweeps the enabled channels in ascending order, gating one shared edge counter
// per channel for a programmable window and handing each result over valid/ready.
module edge_count_scheduler
    import edge_count_scheduler_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CW    = 32,
    parameter int WIN_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          sig,
    input  logic                    start,
    input  logic [NCH-1:0]          chan_mask,
    input  logic [WIN_W-1:0]        window,
    output logic                    busy,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [chan_w(NCH)-1:0]  res_chan,
    output logic [CW-1:0]           res_count,
    output logic                    res_ovf,
    output logic                    sweep_done
);

    localparam int CHW = chan_w(NCH);

    logic [NCH-1:0]   sig_p0, sig_p1;
    state_t           state;
    logic [NCH-1:0]   mask_q;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] timer;
    logic [CHW-1:0]   ptr;
    logic [CHW-1:0]   first_idx;
    logic [CHW-1:0]   next_idx;
    logic             has_next;
    logic             sel_bit;

    // Synchronizer stage 0 -> stage 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_p0 <= '0;
            sig_p1 <= '0;
        end else begin
            sig_p0 <= sig;
            sig_p1 <= sig_p0;
        end
    end

    assign sel_bit = sig_p1[ptr];

    // Descending scans leave the lowest qualifying index as the winner.
    always_comb begin
        first_idx = '0;
        next_idx  = '0;
        has_next  = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (chan_mask[i]) first_idx = CHW'(i);
            if (mask_q[i] && (CHW'(i) > ptr)) begin
                next_idx = CHW'(i);
                has_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            mask_q     <= '0;
            win_q      <= '0;
            timer      <= '0;
            ptr        <= '0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (chan_mask != '0) begin
                            mask_q <= chan_mask;
                            win_q  <= (window == '0) ? WIN_W'(1) : window;
                            ptr    <= first_idx;
                            state  <= ST_SELECT;
                        end else begin
                            sweep_done <= 1'b1;
                        end
                    end
                end
                ST_SELECT: begin
                    timer <= win_q;
                    state <= ST_GATE;
                end
                ST_GATE: begin
                    if (timer <= WIN_W'(1)) state <= ST_REPORT;
                    else                    timer <= timer - WIN_W'(1);
                end
                ST_REPORT: begin
                    if (res_ready) begin
                        if (has_next) begin
                            ptr   <= next_idx;
                            state <= ST_SELECT;
                        end else begin
                            state      <= ST_IDLE;
                            sweep_done <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sync_edge_counter #(.CW(CW)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == ST_SELECT),
        .en    (state == ST_GATE),
        .din   (sel_bit),
        .count (res_count),
        .ovf   (res_ovf)
    );

    assign busy      = (state != ST_IDLE);
    assign res_valid = (state == ST_REPORT);
    assign res_chan  = ptr;

endmodule

// File: tb/tb_edge_count_scheduler.sv
// Directed bench for edge_count_scheduler: one 32-bit-counter instance for the
// sweep/latency/reset cases and one 4-bit-counter instance for saturation.
module tb_edge_count_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sig;
    logic        start, res_ready;
    logic [3:0]  chan_mask;
    logic [15:0] window;
    logic        busy, res_valid, res_ovf, sweep_done;
    logic [1:0]  res_chan;
    logic [31:0] res_count;

    logic [3:0]  sig2;
    logic        start2, ready2;
    logic [3:0]  mask2;
    logic [15:0] win2;
    logic        busy2, valid2, ovf2, done2;
    logic [1:0]  chan2;
    logic [3:0]  count2;

    logic [7:0]  sig_gen = '0;
    int          ph [8] = '{default: 0};
    int          half [8];
    logic [3:0]  sig_man, use_man;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    // Channel waveforms: half[i] is the half period in clk cycles, 0 holds the level.
    always begin
        #10;
        for (int i = 0; i < 8; i++) begin
            if (half[i] != 0) begin
                ph[i] = ph[i] + 1;
                if (ph[i] >= half[i]) begin
                    ph[i] = 0;
                    sig_gen[i] = ~sig_gen[i];
                end
            end
        end
    end

    assign sig  = (sig_gen[3:0] & ~use_man) | (sig_man & use_man);
    assign sig2 = sig_gen[7:4];

    always @(negedge clk) if (sweep_done === 1'b1) done_cnt++;

    edge_count_scheduler #(.NCH(4), .CW(32), .WIN_W(16)) dut (
        .clk(clk), .rst(rst), .sig(sig), .start(start), .chan_mask(chan_mask),
        .window(window), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_chan(res_chan), .res_count(res_count), .res_ovf(res_ovf),
        .sweep_done(sweep_done)
    );

    edge_count_scheduler #(.NCH(4), .CW(4), .WIN_W(16)) dut4 (
        .clk(clk), .rst(rst), .sig(sig2), .start(start2), .chan_mask(mask2),
        .window(win2), .busy(busy2), .res_valid(valid2), .res_ready(ready2),
        .res_chan(chan2), .res_count(count2), .res_ovf(ovf2),
        .sweep_done(done2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input logic [63:0] obs,
                             input logic [63:0] lo, input logic [63:0] hi);
        logic ok;
        n_tests++;
        ok = (obs >= lo) && (obs <= hi);
        assert (ok === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic pulse_start(input logic [3:0] m, input logic [15:0] w);
        chan_mask = m;
        window    = w;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int cyc);
        cyc = 0;
        while (res_valid !== 1'b1 && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        int d0;
        logic stable;
        logic [31:0] c1;

        rst = 1'b1;
        start = 0; res_ready = 0; chan_mask = '0; window = '0;
        start2 = 0; ready2 = 0; mask2 = '0; win2 = '0;
        sig_man = '0; use_man = '0;
        half = '{5, 4, 0, 10, 1, 0, 0, 0};
        repeat (3) tick();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_count", res_count, 0);
        check("rst_chan", res_chan, 0);
        check("rst_ovf", res_ovf, 0);
        check("rst_done", sweep_done, 0);
        rst = 1'b0;
        repeat (4) tick();

        // Single channel, window 100, period 10
        pulse_start(4'b0001, 16'd100);
        check("t1_busy", busy, 1);
        wait_valid(300, cyc);
        check("t1_latency", cyc, 101);
        check("t1_chan", res_chan, 0);
        check_rng("t1_count", res_count, 9, 11);
        check("t1_ovf", res_ovf, 0);
        handshake();
        check("t1_done", sweep_done, 1);
        check("t1_busy_end", busy, 0);
        check("t1_valid_end", res_valid, 0);
        tick();
        check("t1_done_pulse", sweep_done, 0);

        // Two channels with a stalled consumer on the first result
        d0 = done_cnt;
        pulse_start(4'b1010, 16'd80);
        wait_valid(300, cyc);
        check("t2_latency1", cyc, 81);
        check("t2_chan1", res_chan, 1);
        check_rng("t2_count1", res_count, 9, 11);
        check("t2_ovf1", res_ovf, 0);
        c1 = res_count;
        stable = 1'b1;
        repeat (15) begin
            tick();
            if (res_valid !== 1'b1 || res_chan !== 2'd1 || res_count !== c1) stable = 1'b0;
        end
        check("t2_stable", stable, 1);
        handshake();
        check("t2_select_valid", res_valid, 0);
        check("t2_select_busy", busy, 1);
        check("t2_mid_done", sweep_done, 0);
        wait_valid(300, cyc);
        check("t2_latency3", cyc, 81);
        check("t2_chan3", res_chan, 3);
        check_rng("t2_count3", res_count, 3, 5);
        handshake();
        repeat (2) tick();
        check("t2_done_pulses", done_cnt - d0, 1);

        // Saturation on the 4-bit instance
        mask2 = 4'b0001; win2 = 16'd64; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cyc = 0;
        while (valid2 !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
        check("t3_latency", cyc, 65);
        check("t3_count", count2, 15);
        check("t3_ovf", ovf2, 1);
        ready2 = 1'b1;
        tick();
        ready2 = 1'b0;
        check("t3_done", done2, 1);

        // Window 0 behaves as 1: constant-high input, then one edge in the gate
        use_man[2] = 1'b1;
        sig_man[2] = 1'b1;
        repeat (4) tick();
        pulse_start(4'b0100, 16'd0);
        wait_valid(50, cyc);
        check("t4_latency", cyc, 2);
        check("t4_count_hi", res_count, 0);
        handshake();
        sig_man[2] = 1'b0;
        repeat (4) tick();
        sig_man[2] = 1'b1;
        pulse_start(4'b0100, 16'd0);
        wait_valid(50, cyc);
        check("t4_latency_edge", cyc, 2);
        check("t4_count_edge", res_count, 1);
        handshake();
        tick();

        // Asynchronous reset in the middle of a gate
        pulse_start(4'b0010, 16'd100);
        repeat (20) tick();
        check("t5_pre_busy", busy, 1);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        check("t5_busy", busy, 0);
        check("t5_valid", res_valid, 0);
        check("t5_count", res_count, 0);
        check("t5_chan", res_chan, 0);
        check("t5_ovf", res_ovf, 0);
        check("t5_done", sweep_done, 0);
        repeat (2) tick();
        rst = 1'b0;
        use_man[2] = 1'b0;
        half[2] = 5;
        repeat (3) tick();
        check("t5_no_done", done_cnt - d0, 0);
        pulse_start(4'b0100, 16'd10);
        wait_valid(100, cyc);
        check("t5_latency", cyc, 11);
        check("t5_chan2", res_chan, 2);
        check_rng("t5_count2", res_count, 0, 2);

        // start in REPORT is ignored
        chan_mask = 4'b0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_valid_hold", res_valid, 1);
        check("t6_chan_hold", res_chan, 2);
        handshake();
        check("t6_done", sweep_done, 1);
        check("t6_busy", busy, 0);
        repeat (5) tick();
        check("t6_no_result", res_valid, 0);
        check("t6_idle", busy, 0);

        // Empty mask: immediate sweep_done, never busy
        d0 = done_cnt;
        pulse_start(4'b0000, 16'd50);
        check("t7_done", sweep_done, 1);
        check("t7_busy", busy, 0);
        tick();
        check("t7_done_clr", sweep_done, 0);
        check("t7_busy2", busy, 0);
        check("t7_pulses", done_cnt - d0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
